// File: rtl/zero_skip_scheduler.sv
// zero_skip_scheduler: sequencer for the PE zero-flag shift buffer.
// Admits operands into the buffer, scans a WINDOW-tap window by read
// address, enables the MAC only on non-zero taps, emits one psum per
// window and slides the window by STRIDE shifts.
module zero_skip_scheduler #(
  parameter int MEM_DEPTH  = 12,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int WINDOW     = 3,
  parameter int STRIDE     = 1,
  parameter int OUT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OUT_W-1:0]      num_outputs,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  buf_w_en,
  output logic                  buf_shift,
  output logic [ADDR_WIDTH-1:0] buf_r_addr,
  input  logic                  zero_flag,
  output logic                  mac_en,
  output logic                  acc_clear,
  output logic                  psum_valid,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           skip_count
);

  localparam int OCC_W = $clog2(MEM_DEPTH + 1);
  localparam int SL_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SCAN,
    S_EMIT,
    S_SLIDE,
    S_DONE
  } state_t;

  state_t                state;
  logic [OCC_W-1:0]      occ;
  logic [ADDR_WIDTH-1:0] tap;
  logic [OUT_W-1:0]      out_idx;
  logic [OUT_W-1:0]      num_lat;
  logic [SL_W-1:0]       slide_cnt;
  logic                  armed;

  // armed holds in_ready low for the cycle following reset so every output
  // reads 0 straight out of reset; writes are blocked while shifting
  // because the buffer would give the shift priority and lose the word.
  assign in_ready   = armed & (occ < OCC_W'(MEM_DEPTH)) & (state != S_SLIDE);
  assign buf_w_en   = in_valid & in_ready;
  assign buf_r_addr = tap;
  // zero_flag refers to the address presented this cycle, so the MAC
  // enable is a same-cycle decode rather than a registered strobe.
  assign mac_en     = (state == S_SCAN) & ~zero_flag;

  // Occupancy mirrors the buffer fill level; write and shift never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (buf_w_en) begin
      occ <= occ + OCC_W'(1);
    end else if (buf_shift) begin
      occ <= occ - OCC_W'(1);
    end
  end

  // Pass sequencing with registered strobes set on entry to each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tap        <= '0;
      out_idx    <= '0;
      num_lat    <= '0;
      slide_cnt  <= '0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      psum_valid <= 1'b0;
      acc_clear  <= 1'b0;
      buf_shift  <= 1'b0;
      skip_count <= '0;
    end else begin
      armed      <= 1'b1;
      done       <= 1'b0;
      psum_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat    <= num_outputs;
            skip_count <= '0;
            out_idx    <= '0;
            busy       <= 1'b1;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (num_lat == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (occ >= OCC_W'(WINDOW)) begin
            tap       <= '0;
            acc_clear <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          // One tap per cycle regardless of zeros: skipping gates power only.
          acc_clear <= 1'b0;
          if (zero_flag) skip_count <= skip_count + 16'd1;
          if (tap == ADDR_WIDTH'(WINDOW - 1)) begin
            tap        <= '0;
            psum_valid <= 1'b1;
            state      <= S_EMIT;
          end else begin
            tap <= tap + ADDR_WIDTH'(1);
          end
        end
        S_EMIT: begin
          out_idx <= out_idx + OUT_W'(1);
          if (out_idx == num_lat - OUT_W'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            slide_cnt <= '0;
            buf_shift <= 1'b1;
            state     <= S_SLIDE;
          end
        end
        S_SLIDE: begin
          if (slide_cnt == SL_W'(STRIDE - 1)) begin
            buf_shift <= 1'b0;
            state     <= S_FILL;
          end else begin
            slide_cnt <= slide_cnt + SL_W'(1);
          end
        end
        S_DONE: begin
          // Occupancy is kept so leftover operands seed the next pass.
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_skip_scheduler.sv
// Directed bench for zero_skip_scheduler with a behavioural zero-flag buffer.
module tb_zero_skip_scheduler;
  localparam int MEM_DEPTH = 12;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int WINDOW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    num_outputs = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, buf_w_en, buf_shift, zero_flag;
  logic [AW-1:0] buf_r_addr;
  logic          mac_en, acc_clear, psum_valid, busy, done;
  logic [15:0]   skip_count;

  zero_skip_scheduler #(.MEM_DEPTH(MEM_DEPTH), .WINDOW(WINDOW), .STRIDE(1), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_outputs(num_outputs),
    .in_valid(in_valid), .in_ready(in_ready), .buf_w_en(buf_w_en),
    .buf_shift(buf_shift), .buf_r_addr(buf_r_addr), .zero_flag(zero_flag),
    .mac_en(mac_en), .acc_clear(acc_clear), .psum_valid(psum_valid),
    .busy(busy), .done(done), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  // buffer model and upstream source
  logic [7:0] mem [0:15];
  int         mcnt = 0;
  logic [7:0] in_data = '0;
  logic [7:0] src [$];
  bit         accepted = 1'b0;

  // monitors
  int mac_cnt, ac_cnt, psum_cnt, sh_cnt, done_cnt, w_cnt, clash, rec_left;
  logic [15:0] pat;
  int n_chk = 0, n_pass = 0;

  always_comb zero_flag = (mem[buf_r_addr] == 8'd0);

  // mid-cycle: record strobes, then apply them to the buffer model
  always @(negedge clk) begin
    if (reset) begin
      mcnt = 0;
      accepted = 1'b0;
    end else begin
      if (buf_w_en) w_cnt++;
      if (mac_en) mac_cnt++;
      if (acc_clear) ac_cnt++;
      if (psum_valid) psum_cnt++;
      if (buf_shift) sh_cnt++;
      if (done) done_cnt++;
      if (buf_w_en && buf_shift) clash++;
      if (acc_clear) rec_left = WINDOW;
      if (rec_left > 0) begin pat = {pat[14:0], mac_en}; rec_left--; end
      if (buf_shift) begin
        for (int i = 0; i < 15; i++) mem[i] = mem[i+1];
        if (mcnt > 0) mcnt--;
      end else if (buf_w_en && mcnt < 16) begin
        mem[mcnt] = in_data;
        mcnt++;
        accepted = 1'b1;
      end
    end
  end

  // upstream: hold the head word valid until it has been written
  always @(posedge clk) begin
    #2;
    if (accepted) begin
      if (src.size() > 0) void'(src.pop_front());
      accepted = 1'b0;
    end
    if (src.size() > 0) begin in_valid = 1'b1; in_data = src[0]; end
    else begin in_valid = 1'b0; in_data = '0; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    mac_cnt = 0; ac_cnt = 0; psum_cnt = 0; sh_cnt = 0; done_cnt = 0;
    w_cnt = 0; clash = 0; rec_left = 0; pat = '0;
  endtask

  task automatic do_reset();
    src.delete();
    start = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    clr_mon();
  endtask

  task automatic launch(input logic [7:0] n);
    num_outputs = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > 0) break;
      tick();
    end
    n_chk++; if (done_cnt == 0) $display("FAIL done_timeout got done_cnt=0 exp >0"); else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    clr_mon();
    reset = 1'b1;
    tick(); tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
    n_chk++; if (done !== 1'b0 || psum_valid !== 1'b0) $display("FAIL rst_done_psum got %b%b exp 00", done, psum_valid); else n_pass++;
    n_chk++; if (buf_shift !== 1'b0 || mac_en !== 1'b0 || acc_clear !== 1'b0) $display("FAIL rst_strobes got %b%b%b exp 000", buf_shift, mac_en, acc_clear); else n_pass++;
    n_chk++; if (skip_count !== 16'd0 || buf_r_addr !== '0) $display("FAIL rst_cnt got %0d/%0d exp 0/0", skip_count, buf_r_addr); else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_ready_after got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    src = '{8'd1, 8'd2, 8'd3, 8'd4};
    launch(8'd2);
    wait_done();
    n_chk++; if (mac_cnt !== 6) $display("FAIL basic_mac got %0d exp 6", mac_cnt); else n_pass++;
    n_chk++; if (ac_cnt !== 2) $display("FAIL basic_acc_clear got %0d exp 2", ac_cnt); else n_pass++;
    n_chk++; if (psum_cnt !== 2) $display("FAIL basic_psum got %0d exp 2", psum_cnt); else n_pass++;
    n_chk++; if (sh_cnt !== 1) $display("FAIL basic_shift got %0d exp 1", sh_cnt); else n_pass++;
    n_chk++; if (skip_count !== 16'd0) $display("FAIL basic_skip got %0d exp 0", skip_count); else n_pass++;
    n_chk++; if (mcnt !== 3) $display("FAIL basic_occ got %0d exp 3", mcnt); else n_pass++;
    n_chk++; if (pat[5:0] !== 6'b111111) $display("FAIL basic_pattern got %b exp 111111", pat[5:0]); else n_pass++;
    n_chk++; if (busy !== 1'b0 || done_cnt !== 1) $display("FAIL basic_end got busy=%b done_cnt=%0d exp 0/1", busy, done_cnt); else n_pass++;
  endtask

  task automatic test_zero_skip();
    do_reset();
    src = '{8'd5, 8'd0, 8'd7, 8'd0};
    launch(8'd2);
    wait_done();
    n_chk++; if (pat[5:0] !== 6'b101010) $display("FAIL zero_pattern got %b exp 101010", pat[5:0]); else n_pass++;
    n_chk++; if (skip_count !== 16'd3) $display("FAIL zero_skip_count got %0d exp 3", skip_count); else n_pass++;
    n_chk++; if (psum_cnt !== 2) $display("FAIL zero_psum got %0d exp 2", psum_cnt); else n_pass++;
    n_chk++; if (ac_cnt !== 2) $display("FAIL zero_acc_clear got %0d exp 2", ac_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 14; i++) src.push_back(8'(i + 1));
    for (int i = 0; i < 20; i++) tick();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready); else n_pass++;
    n_chk++; if (w_cnt !== 12 || mcnt !== 12) $display("FAIL bp_accepted got %0d/%0d exp 12/12", w_cnt, mcnt); else n_pass++;
    n_chk++; if (src.size() !== 2) $display("FAIL bp_pending got %0d exp 2", src.size()); else n_pass++;
    launch(8'd2);
    wait_done();
    n_chk++; if (clash !== 0) $display("FAIL bp_write_during_shift got %0d exp 0", clash); else n_pass++;
    n_chk++; if (w_cnt !== 13 || mcnt !== 12) $display("FAIL bp_refill got %0d/%0d exp 13/12", w_cnt, mcnt); else n_pass++;
    n_chk++; if (psum_cnt !== 2 || sh_cnt !== 1) $display("FAIL bp_pass got psum=%0d shift=%0d exp 2/1", psum_cnt, sh_cnt); else n_pass++;
  endtask

  task automatic test_starvation();
    do_reset();
    src = '{8'd3, 8'd4};
    launch(8'd1);
    for (int i = 0; i < 8; i++) tick();
    n_chk++; if (busy !== 1'b1 || mac_cnt !== 0 || ac_cnt !== 0) $display("FAIL starve_wait got busy=%b mac=%0d clr=%0d exp 1/0/0", busy, mac_cnt, ac_cnt); else n_pass++;
    n_chk++; if (mcnt !== 2) $display("FAIL starve_occ got %0d exp 2", mcnt); else n_pass++;
    src.push_back(8'd6);
    tick();
    n_chk++; if (acc_clear !== 1'b0) $display("FAIL starve_accept_cycle got %b exp 0", acc_clear); else n_pass++;
    tick();
    n_chk++; if (acc_clear !== 1'b1 || mac_en !== 1'b1) $display("FAIL starve_scan got %b%b exp 11", acc_clear, mac_en); else n_pass++;
    wait_done();
    n_chk++; if (psum_cnt !== 1) $display("FAIL starve_psum got %0d exp 1", psum_cnt); else n_pass++;
  endtask

  task automatic test_num_zero_busy_start();
    do_reset();
    launch(8'd0);
    n_chk++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL n0_cycle1 got busy=%b done=%b exp 1/0", busy, done); else n_pass++;
    tick();
    n_chk++; if (done !== 1'b1) $display("FAIL n0_done got %b exp 1", done); else n_pass++;
    tick();
    n_chk++; if (busy !== 1'b0 || psum_cnt !== 0) $display("FAIL n0_end got busy=%b psum=%0d exp 0/0", busy, psum_cnt); else n_pass++;
    clr_mon();
    launch(8'd1);
    for (int i = 0; i < 3; i++) tick();
    launch(8'd5);
    src = '{8'd1, 8'd1, 8'd1};
    wait_done();
    for (int i = 0; i < 3; i++) tick();
    n_chk++; if (psum_cnt !== 1 || done_cnt !== 1) $display("FAIL busy_start got psum=%0d done=%0d exp 1/1", psum_cnt, done_cnt); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL busy_start_idle got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    src = '{8'd0, 8'd1, 8'd2, 8'd3};
    launch(8'd2);
    for (int i = 0; i < 30; i++) begin
      if (acc_clear === 1'b1) break;
      tick();
    end
    tick();
    n_chk++; if (buf_r_addr !== 4'd1 || skip_count !== 16'd1) $display("FAIL mid_tap1 got addr=%0d skip=%0d exp 1/1", buf_r_addr, skip_count); else n_pass++;
    src.delete();
    reset = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL mid_rst got busy=%b in_ready=%b exp 0/0", busy, in_ready); else n_pass++;
    n_chk++; if (skip_count !== 16'd0 || buf_r_addr !== '0 || mac_en !== 1'b0) $display("FAIL mid_rst_cnt got skip=%0d addr=%0d mac=%b exp 0/0/0", skip_count, buf_r_addr, mac_en); else n_pass++;
    tick();
    reset = 1'b0;
    clr_mon();
    src = '{8'd1, 8'd2, 8'd3, 8'd4};
    launch(8'd2);
    wait_done();
    n_chk++; if (mac_cnt !== 6 || psum_cnt !== 2 || sh_cnt !== 1) $display("FAIL mid_rerun got mac=%0d psum=%0d shift=%0d exp 6/2/1", mac_cnt, psum_cnt, sh_cnt); else n_pass++;
    n_chk++; if (skip_count !== 16'd0 || mcnt !== 3) $display("FAIL mid_rerun_state got skip=%0d occ=%0d exp 0/3", skip_count, mcnt); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    clr_mon();
    test_reset();
    test_basic();
    test_zero_skip();
    test_backpressure();
    test_starvation();
    test_num_zero_busy_start();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
